// File: rtl/tdm_demux4.sv
// tdm_demux4 -- receive end of a 4-slot time-division channel.
//
// Counts slots arriving on a shared line, steers each word into a holding
// register, and publishes all four channels together once slot 3 arrives.
//
// Ports:
//   clk          system clock, rising-edge active
//   reset        synchronous, active-high reset
//   din          shared-line word for the current slot
//   valid        din carries a slot word this cycle
//   start        frame sync, marks din as slot 0 (only when valid=1)
//   sel          index of the slot expected next (0..3)
//   busy         high while a frame is partially collected
//   ch0..ch3     last complete frame, slots 0..3
//   frame_valid  one-cycle pulse after ch0..ch3 were updated
//   frame_err    one-cycle pulse when a partial frame is aborted by a start
module tdm_demux4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             valid,
  input  logic             start,
  output logic [1:0]       sel,
  output logic             busy,
  output logic [WIDTH-1:0] ch0,
  output logic [WIDTH-1:0] ch1,
  output logic [WIDTH-1:0] ch2,
  output logic [WIDTH-1:0] ch3,
  output logic             frame_valid,
  output logic             frame_err
);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       sel_reg, sel_next;
  logic             fv_reg, fv_next;
  logic             fe_reg, fe_next;
  logic [2:0]       hold_we;
  logic             ch_load;

  // Slot 3 never needs holding: it is copied straight from din on completion.
  logic [WIDTH-1:0] hold_reg [3];
  logic [WIDTH-1:0] ch_reg   [4];
  logic [WIDTH-1:0] ch_src   [4];

  // State, slot counter and event pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      sel_reg   <= 2'd0;
      fv_reg    <= 1'b0;
      fe_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      fv_reg    <= fv_next;
      fe_reg    <= fe_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    fv_next    = 1'b0;
    fe_next    = 1'b0;
    hold_we    = 3'b000;
    ch_load    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        // Words without a start while idle are dropped silently.
        if (valid && start) begin
          hold_we[0] = 1'b1;
          sel_next   = 2'd1;
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (valid) begin
          if (start) begin
            // Resync: abandon the partial frame and restart at slot 0.
            fe_next    = 1'b1;
            hold_we[0] = 1'b1;
            sel_next   = 2'd1;
          end else if (sel_reg == 2'd3) begin
            ch_load    = 1'b1;
            fv_next    = 1'b1;
            sel_next   = 2'd0;
            state_next = IDLE;
          end else begin
            for (int i = 0; i < 3; i++) begin
              if (sel_reg == 2'(i)) hold_we[i] = 1'b1;
            end
            sel_next = sel_reg + 2'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        sel_next   = 2'd0;
      end
    endcase
  end

  // Per-slot holding registers and published channel registers.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_hold
      always_ff @(posedge clk) begin
        if (reset) begin
          hold_reg[gi] <= '0;
        end else if (hold_we[gi]) begin
          hold_reg[gi] <= din;
        end
      end
    end

    for (gi = 0; gi < 4; gi++) begin : g_ch
      if (gi < 3) begin : g_from_hold
        assign ch_src[gi] = hold_reg[gi];
      end else begin : g_from_line
        assign ch_src[gi] = din;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          ch_reg[gi] <= '0;
        end else if (ch_load) begin
          ch_reg[gi] <= ch_src[gi];
        end
      end
    end
  endgenerate

  assign sel         = sel_reg;
  assign busy        = (state_reg == COLLECT);
  assign ch0         = ch_reg[0];
  assign ch1         = ch_reg[1];
  assign ch2         = ch_reg[2];
  assign ch3         = ch_reg[3];
  assign frame_valid = fv_reg;
  assign frame_err   = fe_reg;

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] din;
  logic       valid;
  logic       start;
  logic [1:0] sel;
  logic       busy;
  logic [3:0] ch0, ch1, ch2, ch3;
  logic       frame_valid;
  logic       frame_err;

  tdm_demux4 #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .valid      (valid),
    .start      (start),
    .sel        (sel),
    .busy       (busy),
    .ch0        (ch0),
    .ch1        (ch1),
    .ch2        (ch2),
    .ch3        (ch3),
    .frame_valid(frame_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Scoreboard: expected frames {ch3,ch2,ch1,ch0} and pending error pulses.
  logic [15:0] exp_q[$];
  int          err_pending = 0;
  logic [15:0] exp_ch = 16'h0;
  logic        rst_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reset as seen by the DUT on the last rising edge.
  always @(posedge clk) rst_q <= reset;

  // Monitor: compares published channels and event pulses against the queue.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_q !== 1'b0) begin
      exp_ch = 16'h0;
    end else begin
      if (frame_valid && frame_err) chk("fv_fe_overlap", 1, 0);
      if (frame_valid) begin
        chk("frame_valid_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("frame_ch", {ch3, ch2, ch1, ch0}, e);
          exp_ch = e;
          $display("frame published ch0..ch3=%0h,%0h,%0h,%0h", ch0, ch1, ch2, ch3);
        end
      end else begin
        chk("ch_stable", {ch3, ch2, ch1, ch0}, exp_ch);
      end
      if (frame_err) begin
        chk("frame_err_expected", 32'(err_pending > 0), 1);
        if (err_pending > 0) err_pending--;
        $display("frame_err pulse");
      end
    end
  end

  task automatic slot(input logic [3:0] d, input logic s);
    din   = d;
    valid = 1'b1;
    start = s;
    @(posedge clk);
    #1;
    valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic idle_check(input int n, input logic [1:0] exp_sel, input logic exp_busy);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("sel_hold", sel, exp_sel);
      chk("busy_hold", busy, exp_busy);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d, input int gap);
    logic [3:0] w [4];
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    exp_q.push_back({d, c, b, a});
    for (int i = 0; i < 4; i++) begin
      slot(w[i], i == 0);
      if (i < 3 && gap > 0) idle_check(gap, 2'(i + 1), 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    din   = 4'h0;
    valid = 1'b0;
    start = 1'b0;

    // Reset then idle.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ch", {ch3, ch2, ch1, ch0}, 16'h0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_fe", frame_err, 0);

    // Clean frame.
    frame(4'hA, 4'hB, 4'hC, 4'hD, 0);
    @(negedge clk);
    chk("clean_sel", sel, 0);
    chk("clean_busy", busy, 0);
    chk("clean_fv", frame_valid, 1);
    @(negedge clk);
    chk("clean_fv_once", frame_valid, 0);

    // Stray word while idle, then a gapped frame.
    slot(4'h5, 1'b0);
    @(negedge clk);
    chk("stray_sel", sel, 0);
    chk("stray_busy", busy, 0);
    frame(4'h1, 4'h2, 4'h3, 4'h4, 2);
    repeat (2) @(posedge clk);
    #1;

    // Resync mid-frame.
    slot(4'h7, 1'b1);
    slot(4'h8, 1'b0);
    err_pending++;
    slot(4'h9, 1'b1);
    @(negedge clk);
    chk("resync_fe", frame_err, 1);
    chk("resync_sel", sel, 1);
    exp_q.push_back(16'hCBA9);
    slot(4'hA, 1'b0);
    slot(4'hB, 1'b0);
    slot(4'hC, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back frames.
    frame(4'h1, 4'h2, 4'h3, 4'h4, 0);
    frame(4'h5, 4'h6, 4'h7, 4'h8, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-frame.
    slot(4'hF, 1'b1);
    slot(4'hE, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_sel", sel, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ch", {ch3, ch2, ch1, ch0}, 16'h0);
    slot(4'h3, 1'b0);
    @(negedge clk);
    chk("post_rst_stray_busy", busy, 0);
    frame(4'h6, 4'h5, 4'h4, 4'h3, 1);
    repeat (3) @(posedge clk);
    #1;

    chk("frames_outstanding", exp_q.size(), 0);
    chk("errors_outstanding", err_pending, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive end of the team's 4-way time-division channel. The transmit side steps a 2-bit select through slots 0..3 and places one channel per slot on a shared line.
- This block counts slots on the receive side, steers each word into a per-channel holding register, and publishes all four channels atomically once a full frame has arrived.
- It sits between the shared line and downstream logic (display/LED drivers) that need four stable, parallel channel values.

Parameters:
- WIDTH, 4, bit width of each channel word on the shared line and on each channel output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  WIDTH  shared-line data word for the current slot.
- valid  input  1  din holds a slot word this cycle.
- start  input  1  frame sync; qualifies din as slot 0. Ignored when valid=0.
- sel  output  2  index of the slot expected next (0..3).
- busy  output  1  high while a frame is partially collected (state COLLECT).
- ch0, ch1, ch2, ch3  output  WIDTH each  last complete frame, slots 0..3.
- frame_valid  output  1  one-cycle pulse when ch0..ch3 have just been updated.
- frame_err  output  1  one-cycle pulse when a partial frame is aborted by a new start.

Behaviour:
- Reset (synchronous, sampled on a clk edge) sets the following, and overrides every other input that cycle:
  - state=IDLE, sel=0, busy=0
  - ch0..ch3=0, holding registers=0
  - frame_valid=0, frame_err=0
- Reset asserted mid-frame discards the partial frame. No frame_valid or frame_err pulse results.
- States: IDLE and COLLECT. busy=1 exactly when the state is COLLECT.
- IDLE:
  - valid=1, start=1: hold[0]<=din, sel<=1, go to COLLECT.
  - valid=1, start=0: word dropped, no error, stay in IDLE, sel stays 0.
  - valid=0: no change.
- COLLECT:
  - valid=0: hold all state. Gaps of any length between slots are legal.
  - valid=1, start=0, sel<3: hold[sel]<=din, sel<=sel+1.
  - valid=1, start=0, sel==3: the final slot completes the frame:
    - on this same edge, ch0<=hold[0], ch1<=hold[1], ch2<=hold[2], ch3<=din
    - frame_valid<=1
    - sel<=0 (wrap-around), go to IDLE
  - valid=1, start=1 (resync mid-frame): frame_err<=1 for one cycle, partial frame discarded (ch outputs unchanged), hold[0]<=din, sel<=1, stay in COLLECT.
- Latency: ch0..ch3 and frame_valid become visible in the cycle after the edge that samples slot 3 (1 clk).
- Back-to-back frames: a start in the cycle immediately after slot 3 is accepted as slot 0 of the next frame with no bubble. Sustained throughput is one slot word per clk.
- frame_valid and frame_err are registered. Each is 1 for exactly one cycle per event and never asserted in the same cycle.
- ch0..ch3 change only on frame completion or reset; they are otherwise stable, glitch-free registers.
- Width rules:
  - sel is 2 bits and wraps 3→0 only through frame completion. It never increments past 3.
  - Data is passed through unmodified, with no width conversion.

Test Plan:
- Reset then idle: assert reset 2 cycles, WIDTH=4 → sel=0, busy=0, ch0..ch3=0, frame_valid=0, frame_err=0 on the cycle after reset deasserts.
- Clean frame: valid=1 on 4 consecutive cycles, din=A,B,C,D, start=1 on the first only → one cycle after D: ch0=A, ch1=B, ch2=C, ch3=D, frame_valid=1 for 1 cycle, sel=0, busy=0.
- Gapped frame plus stray word:
  - din=5 with valid=1, start=0 while IDLE → ignored.
  - Then frame 1,2,3,4 with 2 idle cycles (valid=0) between each slot → ch=1,2,3,4 and a single frame_valid pulse.
  - sel holds during gaps.
- Resync: start frame 7,8, then valid=1, start=1, din=9, then 0xA,0xB,0xC:
  - frame_err pulses one cycle after the second start.
  - ch unchanged until completion, then ch0..ch3=9,A,B,C, with exactly one frame_valid pulse.
- Back-to-back: frames (1,2,3,4) and (5,6,7,8) with no idle cycle between →
  - frame_valid pulses one cycle after 4 and again one cycle after 8.
  - ch=1,2,3,4 is then replaced by 5,6,7,8.
  - No frame_err.
- Reset mid-frame: after slots F,E of a frame, assert reset for 1 cycle →
  - sel=0, busy=0, ch=0.
  - A following start-less word is ignored.
  - A new full frame completes normally.
